// File: rtl/booth_mult_r4.sv
// Sequential radix-4 (modified) Booth multiplier, two multiplier bits per clock.
// Operands are extended by two bits on capture so signed and unsigned share one datapath.
module booth_mult_r4 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned E  = WIDTH + 2;
    localparam int unsigned N  = E / 2;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned PW = 2 * WIDTH;

    // Reject odd or too-narrow operand widths at elaboration
    if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("booth_mult_r4: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [E:0]      a_q, a_d;
    logic [E-1:0]    qs_q, qs_d;
    logic            qm1_q, qm1_d;
    logic [E:0]      mx_q, mx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [PW-1:0]   product_q, product_d;

    logic [E:0]      mx2_c;
    logic [E:0]      addend_c;
    logic [E:0]      sum_c;
    logic [2*E+1:0]  shifted_c;
    logic [PW-1:0]   result_c;
    logic            msign_c;
    logic            qsign_c;

    // Booth recoding, accumulate and 2-bit arithmetic shift for one iteration
    always_comb begin
        mx2_c    = {mx_q[E-1:0], 1'b0};
        addend_c = '0;
        case ({qs_q[1:0], qm1_q})
            3'b001, 3'b010: addend_c = mx_q;
            3'b011:         addend_c = mx2_c;
            3'b100:         addend_c = -mx2_c;
            3'b101, 3'b110: addend_c = -mx_q;
            default:        addend_c = '0;
        endcase
        sum_c     = a_q + addend_c;
        shifted_c = $signed({sum_c, qs_q, qm1_q}) >>> 2;
        result_c  = PW'({a_q, qs_q});
        msign_c   = signed_mode & multiplicand[WIDTH-1];
        qsign_c   = signed_mode & multiplier[WIDTH-1];
    end

    // Next-state and register-update logic
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        qs_d      = qs_q;
        qm1_d     = qm1_q;
        mx_d      = mx_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = '0;
                    qs_d    = {{2{qsign_c}}, multiplier};
                    qm1_d   = 1'b0;
                    mx_d    = {{3{msign_c}}, multiplicand};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                a_d   = shifted_c[2*E+1:E+1];
                qs_d  = shifted_c[E:1];
                qm1_d = shifted_c[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                product_d = result_c;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            qs_q      <= '0;
            qm1_q     <= 1'b0;
            mx_q      <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            qs_q      <= qs_d;
            qm1_q     <= qm1_d;
            mx_q      <= mx_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_mult_r4.sv
// Directed and randomised checks for booth_mult_r4 at WIDTH=8 and WIDTH=16.
module tb_booth_mult_r4;

    logic        clk;
    logic        rst;

    logic        s8_start, s8_mode, s8_busy, s8_done;
    logic [7:0]  s8_m, s8_q;
    logic [15:0] s8_prod;

    logic        s16_start, s16_mode, s16_busy, s16_done;
    logic [15:0] s16_m, s16_q;
    logic [31:0] s16_prod;

    int errors;
    int checks;

    booth_mult_r4 #(.WIDTH(8)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .start        (s8_start),
        .signed_mode  (s8_mode),
        .multiplicand (s8_m),
        .multiplier   (s8_q),
        .busy         (s8_busy),
        .done         (s8_done),
        .product      (s8_prod)
    );

    booth_mult_r4 #(.WIDTH(16)) u_dut16 (
        .clk          (clk),
        .rst          (rst),
        .start        (s16_start),
        .signed_mode  (s16_mode),
        .multiplicand (s16_m),
        .multiplier   (s16_q),
        .busy         (s16_busy),
        .done         (s16_done),
        .product      (s16_prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for done on the 8-bit unit; lat = cycles waited, -1 on timeout
    task automatic wait_done8(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (s8_done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_done16(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (s16_done) begin
                lat = i;
                break;
            end
        end
    endtask

    // One full operation on the 8-bit unit
    task automatic op8(input logic sm, input logic [7:0] m, input logic [7:0] q,
                       output logic [15:0] p, output int lat);
        @(negedge clk);
        s8_mode = sm; s8_m = m; s8_q = q; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        wait_done8(lat);
        p = s8_prod;
    endtask

    task automatic op16(input logic sm, input logic [15:0] m, input logic [15:0] q,
                        output logic [31:0] p, output int lat);
        @(negedge clk);
        s16_mode = sm; s16_m = m; s16_q = q; s16_start = 1'b1;
        @(posedge clk); #1;
        s16_start = 1'b0;
        wait_done16(lat);
        p = s16_prod;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (s8_busy !== 1'b0 || s8_done !== 1'b0 || s8_prod !== 16'h0) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b product=%h, want 0 0 0000", s8_busy, s8_done, s8_prod);
        end
        checks++;
        if (s16_busy !== 1'b0 || s16_done !== 1'b0 || s16_prod !== 32'h0) begin
            errors++;
            $display("FAIL reset16: busy=%b done=%b product=%h, want 0 0 0", s16_busy, s16_done, s16_prod);
        end
    endtask

    task automatic test_signed8();
        logic [15:0] p;
        int lat;
        op8(1'b1, 8'h80, 8'h80, p, lat);
        checks++;
        if (p !== 16'h4000) begin
            errors++; $display("FAIL s8_min_min: product=%h want 4000", p);
        end
        checks++;
        if (lat != 6) begin
            errors++; $display("FAIL s8_latency: got %0d want 6", lat);
        end
        checks++;
        if (s8_busy !== 1'b0) begin
            errors++; $display("FAIL s8_busy_at_done: busy=%b want 0", s8_busy);
        end
        @(posedge clk); #1;
        checks++;
        if (s8_done !== 1'b0) begin
            errors++; $display("FAIL s8_done_width: done=%b want 0", s8_done);
        end
        op8(1'b1, 8'hFF, 8'hFF, p, lat);
        checks++;
        if (p !== 16'h0001) begin
            errors++; $display("FAIL s8_m1_m1: product=%h want 0001", p);
        end
        op8(1'b1, 8'h00, 8'h55, p, lat);
        checks++;
        if (p !== 16'h0000) begin
            errors++; $display("FAIL s8_zero: product=%h want 0000", p);
        end
    endtask

    // Operand and mode inputs are scrambled while busy; captured copies must be used
    task automatic test_input_hold();
        int lat;
        @(negedge clk);
        s8_mode = 1'b1; s8_m = 8'h7F; s8_q = 8'h80; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0; s8_mode = 1'b0; s8_m = 8'h11; s8_q = 8'h22;
        wait_done8(lat);
        checks++;
        if (s8_prod !== 16'hC080 || lat != 6) begin
            errors++; $display("FAIL s8_hold_127x-128: product=%h lat=%0d want C080 6", s8_prod, lat);
        end
    endtask

    task automatic test_unsigned8();
        logic [15:0] p;
        int lat;
        op8(1'b0, 8'hFF, 8'hFF, p, lat);
        checks++;
        if (p !== 16'hFE01) begin
            errors++; $display("FAIL u8_255x255: product=%h want FE01", p);
        end
        op8(1'b0, 8'h80, 8'h02, p, lat);
        checks++;
        if (p !== 16'h0100) begin
            errors++; $display("FAIL u8_80x2: product=%h want 0100", p);
        end
        op8(1'b1, 8'h80, 8'h02, p, lat);
        checks++;
        if (p !== 16'hFF00) begin
            errors++; $display("FAIL s8_80x2: product=%h want FF00", p);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        int pulses;
        @(negedge clk);
        s8_mode = 1'b0; s8_m = 8'd3; s8_q = 8'd5; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        checks++;
        if (s8_busy !== 1'b1) begin
            errors++; $display("FAIL busy_after_start: busy=%b want 1", s8_busy);
        end
        repeat (2) @(posedge clk);
        #1;
        s8_m = 8'd9; s8_q = 8'd9; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        wait_done8(lat);
        checks++;
        if (s8_prod !== 16'd15 || lat != 3) begin
            errors++; $display("FAIL busy_ignore: product=%0d lat=%0d want 15 3", s8_prod, lat);
        end
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (s8_done) pulses++;
        end
        checks++;
        if (pulses != 0 || s8_prod !== 16'd15) begin
            errors++; $display("FAIL busy_single_done: extra pulses=%0d product=%0d want 0 15", pulses, s8_prod);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p;
        int lat;
        op8(1'b0, 8'd4, 8'd4, p, lat);
        checks++;
        if (p !== 16'd16) begin
            errors++; $display("FAIL b2b_first: product=%0d want 16", p);
        end
        // still in the done cycle: present the next request now
        s8_mode = 1'b0; s8_m = 8'd7; s8_q = 8'd7; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        checks++;
        if (s8_busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: busy=%b want 1", s8_busy);
        end
        wait_done8(lat);
        checks++;
        if (s8_prod !== 16'd49 || lat != 6) begin
            errors++; $display("FAIL b2b_second: product=%0d lat=%0d want 49 6", s8_prod, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] p;
        int lat;
        int pulses;
        @(negedge clk);
        s8_mode = 1'b0; s8_m = 8'd100; s8_q = 8'd100; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (s8_busy !== 1'b0 || s8_done !== 1'b0 || s8_prod !== 16'h0) begin
            errors++; $display("FAIL mid_reset: busy=%b done=%b product=%h want 0 0 0000", s8_busy, s8_done, s8_prod);
        end
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (s8_done) pulses++;
        end
        checks++;
        if (pulses != 0 || s8_prod !== 16'h0) begin
            errors++; $display("FAIL mid_reset_no_done: pulses=%0d product=%h want 0 0000", pulses, s8_prod);
        end
        op8(1'b0, 8'd2, 8'd3, p, lat);
        checks++;
        if (p !== 16'd6 || lat != 6) begin
            errors++; $display("FAIL after_reset_2x3: product=%0d lat=%0d want 6 6", p, lat);
        end
    endtask

    task automatic test_w16();
        logic [31:0] p;
        logic [31:0] exp;
        logic [15:0] m;
        logic [15:0] q;
        int lat;
        op16(1'b1, 16'h8000, 16'h8000, p, lat);
        checks++;
        if (p !== 32'h4000_0000 || lat != 10) begin
            errors++; $display("FAIL w16_min_min: product=%h lat=%0d want 40000000 10", p, lat);
        end
        for (int k = 0; k < 2000; k++) begin
            logic sm;
            sm = (k < 1000);
            m  = 16'($urandom);
            q  = 16'($urandom);
            if (sm) exp = 32'(longint'($signed(m)) * longint'($signed(q)));
            else    exp = 32'(longint'(m) * longint'(q));
            op16(sm, m, q, p, lat);
            checks++;
            if (p !== exp || lat != 10) begin
                errors++;
                $display("FAIL w16_random mode=%b m=%h q=%h: product=%h lat=%0d want %h 10", sm, m, q, p, lat, exp);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        s8_start = 1'b0;  s8_mode = 1'b0;  s8_m = '0;  s8_q = '0;
        s16_start = 1'b0; s16_mode = 1'b0; s16_m = '0; s16_q = '0;
        test_reset();
        test_signed8();
        test_input_hold();
        test_unsigned8();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_w16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
